// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and redirect controller for a five-stage in-order pipeline.
// It selects operand forwarding sources for the ID stage and inserts one
// bubble for each load-use hazard. It turns EX-stage branch/jump requests
// into a same-cycle PC redirect with a flush of the two wrong-path stages.
// While data memory is busy, the whole pipeline is frozen. A redirect that
// arrives during a freeze is held until the freeze ends. Saturating
// counters record stall cycles and flush cycles.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   i_id_*                          ID-stage valid, rs1/rs2 use flags and indices
//   i_ex_*                          EX-stage valid, write/load qualifiers, rd,
//                                   redirect request and target
//   i_mem_*, i_wb_*                 MEM / WB writer valid, reg_write and rd
//   i_mem_busy                      data memory not ready, freezes the pipeline
//   o_fwd_rs1_sel, o_fwd_rs2_sel    00 regfile, 01 MEM result, 10 WB result
//   o_*_stall                       hold PC / pipeline registers
//   o_if_id_flush, o_id_ex_flush    bubble the stage on the next edge
//   o_pc_redirect_en/_addr          load PC on the next edge (addr 0 when idle)
//   o_stall_count, o_flush_count    saturating performance counters
//
// State   | meaning
// ST_RUN  | normal operation
// ST_PEND | redirect captured during a freeze, issued when the freeze ends
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_id_valid,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_ex_valid,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_redirect_req,
  input  logic [31:0] i_ex_redirect_addr,
  input  logic        i_mem_valid,
  input  logic        i_mem_reg_write,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic        i_wb_valid,
  input  logic        i_wb_reg_write,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic        i_mem_busy,
  output logic [1:0]  o_fwd_rs1_sel,
  output logic [1:0]  o_fwd_rs2_sel,
  output logic        o_pc_stall,
  output logic        o_if_id_stall,
  output logic        o_id_ex_stall,
  output logic        o_ex_mem_stall,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_pc_redirect_en,
  output logic [31:0] o_pc_redirect_addr,
  output logic [15:0] o_stall_count,
  output logic [15:0] o_flush_count
);

  typedef enum logic {ST_RUN, ST_PEND} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pend_addr;
  logic [31:0] w_pend_addr_nxt;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  logic w_mem_wr, w_wb_wr;
  logic w_mem_hit_rs1, w_mem_hit_rs2, w_wb_hit_rs1, w_wb_hit_rs2;
  logic w_load_use, w_redir_req, w_any_stall, w_any_flush;

  // A writer only forwards when it really writes a non-zero register.
  assign w_mem_wr      = i_mem_valid & i_mem_reg_write;
  assign w_wb_wr       = i_wb_valid & i_wb_reg_write;
  assign w_mem_hit_rs1 = w_mem_wr & (i_mem_rd_addr == i_id_rs1_addr) & (i_id_rs1_addr != 5'd0);
  assign w_mem_hit_rs2 = w_mem_wr & (i_mem_rd_addr == i_id_rs2_addr) & (i_id_rs2_addr != 5'd0);
  assign w_wb_hit_rs1  = w_wb_wr & (i_wb_rd_addr == i_id_rs1_addr) & (i_id_rs1_addr != 5'd0);
  assign w_wb_hit_rs2  = w_wb_wr & (i_wb_rd_addr == i_id_rs2_addr) & (i_id_rs2_addr != 5'd0);

  // The bubble moves the load into MEM, so the hazard clears by itself
  // after one cycle. Because of that, no extra state is needed to limit
  // each hazard to a single bubble.
  assign w_load_use = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd_addr != 5'd0) &
                      ((i_id_uses_rs1 & (i_ex_rd_addr == i_id_rs1_addr)) |
                       (i_id_uses_rs2 & (i_ex_rd_addr == i_id_rs2_addr)));

  assign w_redir_req = i_ex_valid & i_ex_redirect_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_pend_addr <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pend_addr_nxt    = r_pend_addr;
    o_fwd_rs1_sel      = 2'b00;
    o_fwd_rs2_sel      = 2'b00;
    o_pc_stall         = 1'b0;
    o_if_id_stall      = 1'b0;
    o_id_ex_stall      = 1'b0;
    o_ex_mem_stall     = 1'b0;
    o_if_id_flush      = 1'b0;
    o_id_ex_flush      = 1'b0;
    o_pc_redirect_en   = 1'b0;
    o_pc_redirect_addr = 32'd0;

    // All outputs are gated by reset, so they stay quiet while rst_n is
    // low even if the inputs are active.
    if (rst_n) begin
      if (w_mem_hit_rs1)     o_fwd_rs1_sel = 2'b01;
      else if (w_wb_hit_rs1) o_fwd_rs1_sel = 2'b10;
      if (w_mem_hit_rs2)     o_fwd_rs2_sel = 2'b01;
      else if (w_wb_hit_rs2) o_fwd_rs2_sel = 2'b10;

      if (i_mem_busy) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_stall = 1'b1;
        // While already pending, new requests are ignored: the captured
        // target is the oldest control transfer and the one that wins.
        if (r_state == ST_RUN && w_redir_req) begin
          w_state_nxt     = ST_PEND;
          w_pend_addr_nxt = i_ex_redirect_addr;
        end
      end else if (r_state == ST_PEND) begin
        o_pc_redirect_en   = 1'b1;
        o_pc_redirect_addr = r_pend_addr;
        o_if_id_flush      = 1'b1;
        o_id_ex_flush      = 1'b1;
        w_state_nxt        = ST_RUN;
      end else if (w_redir_req) begin
        o_pc_redirect_en   = 1'b1;
        o_pc_redirect_addr = i_ex_redirect_addr;
        o_if_id_flush      = 1'b1;
        o_id_ex_flush      = 1'b1;
      end else if (w_load_use) begin
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  assign w_any_stall = o_pc_stall | o_if_id_stall | o_id_ex_stall | o_ex_mem_stall;
  assign w_any_flush = o_if_id_flush | o_id_ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_any_stall && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
      if (w_any_flush && r_flush_count != 16'hFFFF) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic        id_valid;
    logic        uses1;
    logic        uses2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ex_valid;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic        redir;
    logic [31:0] raddr;
    logic        mem_valid;
    logic        mem_rw;
    logic [4:0]  mem_rd;
    logic        wb_valid;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic        busy;
  } in_t;

  typedef struct packed {
    logic [1:0]  fwd1;
    logic [1:0]  fwd2;
    logic [3:0]  stalls;   // {pc, if_id, id_ex, ex_mem}
    logic [1:0]  flushes;  // {if_id, id_ex}
    logic        en;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    string nm;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        ex_redirect_req;
  logic [31:0] ex_redirect_addr;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic        mem_busy;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush;
  logic        pc_redirect_en;
  logic [31:0] pc_redirect_addr;
  logic [15:0] stall_count, flush_count;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: pending redirect plus counters as plain integers.
  bit          m_pend = 0;
  logic [31:0] m_pend_addr = 32'd0;
  int          m_stall_cnt = 0;
  int          m_flush_cnt = 0;

  vec_t vecs[$];

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr),
    .i_ex_valid(ex_valid), .i_ex_reg_write(ex_reg_write), .i_ex_mem_read(ex_mem_read),
    .i_ex_rd_addr(ex_rd_addr), .i_ex_redirect_req(ex_redirect_req),
    .i_ex_redirect_addr(ex_redirect_addr),
    .i_mem_valid(mem_valid), .i_mem_reg_write(mem_reg_write), .i_mem_rd_addr(mem_rd_addr),
    .i_wb_valid(wb_valid), .i_wb_reg_write(wb_reg_write), .i_wb_rd_addr(wb_rd_addr),
    .i_mem_busy(mem_busy),
    .o_fwd_rs1_sel(fwd_rs1_sel), .o_fwd_rs2_sel(fwd_rs2_sel),
    .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_id_ex_stall(id_ex_stall),
    .o_ex_mem_stall(ex_mem_stall), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_pc_redirect_en(pc_redirect_en), .o_pc_redirect_addr(pc_redirect_addr),
    .o_stall_count(stall_count), .o_flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic exp_t e_zero();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_lu();
    exp_t e;
    e = '0;
    e.stalls  = 4'b1100;
    e.flushes = 2'b01;
    return e;
  endfunction

  function automatic exp_t e_freeze();
    exp_t e;
    e = '0;
    e.stalls = 4'b1111;
    return e;
  endfunction

  function automatic exp_t e_redir(input logic [31:0] a);
    exp_t e;
    e = '0;
    e.flushes = 2'b11;
    e.en      = 1'b1;
    e.addr    = a;
    return e;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t v);
    if (rs == 5'd0) return 2'b00;
    if (v.mem_valid && v.mem_rw && v.mem_rd == rs) return 2'b01;
    if (v.wb_valid && v.wb_rw && v.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs for one cycle, derived from the behavioural rules.
  function automatic exp_t ref_model(input in_t v);
    exp_t e;
    bit   lu;
    e      = e_zero();
    lu     = v.id_valid && v.ex_valid && v.ex_mr && v.ex_rd != 5'd0 &&
             ((v.uses1 && v.rs1 == v.ex_rd) || (v.uses2 && v.rs2 == v.ex_rd));
    if (v.busy)                     e = e_freeze();
    else if (m_pend)                e = e_redir(m_pend_addr);
    else if (v.ex_valid && v.redir) e = e_redir(v.raddr);
    else if (lu)                    e = e_lu();
    e.fwd1 = ref_fwd(v.rs1, v);
    e.fwd2 = ref_fwd(v.rs2, v);
    return e;
  endfunction

  function automatic in_t rnd_in();
    in_t v;
    v.id_valid  = 1'($urandom_range(0, 1));
    v.uses1     = 1'($urandom_range(0, 1));
    v.uses2     = 1'($urandom_range(0, 1));
    v.rs1       = 5'($urandom_range(0, 3));
    v.rs2       = 5'($urandom_range(0, 3));
    v.ex_valid  = 1'($urandom_range(0, 1));
    v.ex_rw     = 1'($urandom_range(0, 1));
    v.ex_mr     = 1'($urandom_range(0, 1));
    v.ex_rd     = 5'($urandom_range(0, 3));
    v.redir     = ($urandom_range(0, 4) == 0);
    v.raddr     = $urandom;
    v.mem_valid = 1'($urandom_range(0, 1));
    v.mem_rw    = 1'($urandom_range(0, 1));
    v.mem_rd    = 5'($urandom_range(0, 3));
    v.wb_valid  = 1'($urandom_range(0, 1));
    v.wb_rw     = 1'($urandom_range(0, 1));
    v.wb_rd     = 5'($urandom_range(0, 3));
    v.busy      = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  task automatic drive(input in_t v);
    id_valid         = v.id_valid;
    id_uses_rs1      = v.uses1;
    id_uses_rs2      = v.uses2;
    id_rs1_addr      = v.rs1;
    id_rs2_addr      = v.rs2;
    ex_valid         = v.ex_valid;
    ex_reg_write     = v.ex_rw;
    ex_mem_read      = v.ex_mr;
    ex_rd_addr       = v.ex_rd;
    ex_redirect_req  = v.redir;
    ex_redirect_addr = v.raddr;
    mem_valid        = v.mem_valid;
    mem_reg_write    = v.mem_rw;
    mem_rd_addr      = v.mem_rd;
    wb_valid         = v.wb_valid;
    wb_reg_write     = v.wb_rw;
    wb_rd_addr       = v.wb_rd;
    mem_busy         = v.busy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_outputs(input string nm, input exp_t e);
    chk({nm, " fwd_rs1_sel"}, 32'(fwd_rs1_sel), 32'(e.fwd1));
    chk({nm, " fwd_rs2_sel"}, 32'(fwd_rs2_sel), 32'(e.fwd2));
    chk({nm, " stalls"}, 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall}), 32'(e.stalls));
    chk({nm, " flushes"}, 32'({if_id_flush, id_ex_flush}), 32'(e.flushes));
    chk({nm, " redirect_en"}, 32'(pc_redirect_en), 32'(e.en));
    chk({nm, " redirect_addr"}, pc_redirect_addr, e.addr);
    chk({nm, " stall_count"}, 32'(stall_count), 32'(m_stall_cnt));
    chk({nm, " flush_count"}, 32'(flush_count), 32'(m_flush_cnt));
  endtask

  // Called at posedge+1; drives, checks mid-cycle, then advances the model.
  task automatic run_cycle(input string nm, input in_t v, input exp_t e);
    drive(v);
    #1;
    chk_outputs(nm, e);
    @(posedge clk);
    if (e.stalls != 4'b0000)  m_stall_cnt = (m_stall_cnt >= 65535) ? 65535 : m_stall_cnt + 1;
    if (e.flushes != 2'b00)   m_flush_cnt = (m_flush_cnt >= 65535) ? 65535 : m_flush_cnt + 1;
    if (v.busy) begin
      if (!m_pend && v.ex_valid && v.redir) begin
        m_pend      = 1'b1;
        m_pend_addr = v.raddr;
      end
    end else begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic add_vec(input string nm, input in_t i, input exp_t e);
    vec_t r;
    r.nm = nm;
    r.i  = i;
    r.e  = e;
    vecs.push_back(r);
  endtask

  initial begin
    in_t  v;
    exp_t e;

    // Directed single-cycle vectors, all applied from the RUN state.
    add_vec("idle", idle(), e_zero());

    v = idle(); v.id_valid = 1; v.uses1 = 1; v.uses2 = 1; v.rs1 = 5; v.rs2 = 7;
    v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5;
    add_vec("load_use_rs1", v, e_lu());

    v = idle(); v.id_valid = 1; v.uses1 = 1; v.uses2 = 1; v.rs1 = 5; v.rs2 = 7;
    v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 5;
    e = e_zero(); e.fwd1 = 2'b01;
    add_vec("after_bubble_fwd", v, e);

    v = idle(); v.id_valid = 1; v.uses2 = 1; v.rs1 = 9; v.rs2 = 3;
    v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 3; v.wb_valid = 1; v.wb_rw = 1; v.wb_rd = 3;
    e = e_zero(); e.fwd2 = 2'b01;
    add_vec("mem_beats_wb", v, e);

    v = idle(); v.id_valid = 1; v.rs1 = 3; v.rs2 = 4;
    v.wb_valid = 1; v.wb_rw = 1; v.wb_rd = 3; v.mem_valid = 1; v.mem_rw = 0; v.mem_rd = 3;
    e = e_zero(); e.fwd1 = 2'b10;
    add_vec("wb_fwd_mem_nowrite", v, e);

    v = idle(); v.id_valid = 1; v.rs1 = 0; v.rs2 = 0;
    v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 0; v.wb_valid = 1; v.wb_rw = 1; v.wb_rd = 0;
    add_vec("x0_no_fwd", v, e_zero());

    v = idle(); v.id_valid = 1; v.uses1 = 1; v.rs2 = 7;
    v.ex_valid = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 7;
    add_vec("rs2_unused_no_hazard", v, e_zero());

    v = idle(); v.id_valid = 1; v.uses1 = 1; v.rs1 = 0;
    v.ex_valid = 1; v.ex_mr = 1; v.ex_rd = 0;
    add_vec("x0_load_no_hazard", v, e_zero());

    v = idle(); v.id_valid = 1; v.uses2 = 1; v.rs2 = 12;
    v.ex_valid = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 12;
    add_vec("load_use_rs2", v, e_lu());

    v = idle(); v.ex_valid = 1; v.redir = 1; v.raddr = 32'h0000_0100;
    add_vec("redirect_0x100", v, e_redir(32'h100));

    v = idle(); v.ex_valid = 0; v.redir = 1; v.raddr = 32'h0000_0180;
    add_vec("redirect_unqualified", v, e_zero());

    v = idle(); v.id_valid = 1; v.uses1 = 1; v.rs1 = 5;
    v.ex_valid = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 5; v.redir = 1; v.raddr = 32'h40;
    add_vec("redirect_beats_load_use", v, e_redir(32'h40));

    v = idle(); v.id_valid = 1; v.uses1 = 1; v.rs1 = 5;
    v.ex_valid = 1; v.ex_mr = 1; v.ex_rd = 5; v.busy = 1;
    add_vec("freeze_over_load_use", v, e_freeze());

    // Reset: outputs must be quiet even with active inputs.
    rst_n = 1'b0;
    v = idle(); v.id_valid = 1; v.uses1 = 1; v.rs1 = 5; v.ex_valid = 1; v.ex_mr = 1; v.ex_rd = 5;
    v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 5; v.redir = 1; v.raddr = 32'h77;
    drive(v);
    #2;
    chk_outputs("in_reset", e_zero());
    @(negedge clk);
    drive(idle());
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) run_cycle(vecs[k].nm, vecs[k].i, vecs[k].e);

    // Redirect captured during a three-cycle freeze, issued with the held target.
    v = idle(); v.ex_valid = 1; v.redir = 1; v.raddr = 32'h200; v.busy = 1;
    run_cycle("pend_capture", v, e_freeze());
    v.raddr = 32'h300;
    run_cycle("pend_hold1", v, e_freeze());
    run_cycle("pend_hold2", v, e_freeze());
    v.busy = 0;
    run_cycle("pend_release", v, e_redir(32'h200));
    run_cycle("after_pend_idle", idle(), e_zero());

    for (int n = 0; n < 400; n++) begin
      v = rnd_in();
      run_cycle($sformatf("rand%0d", n), v, ref_model(v));
    end

    // Drain any pending redirect left by the random phase.
    run_cycle("drain", idle(), ref_model(idle()));

    // Enter PEND, then reset: the pending redirect must be discarded.
    v = idle(); v.ex_valid = 1; v.redir = 1; v.raddr = 32'h500; v.busy = 1;
    run_cycle("pend_before_reset", v, e_freeze());
    rst_n = 1'b0;
    v = idle(); v.ex_valid = 1; v.redir = 1; v.raddr = 32'h600;
    v.id_valid = 1; v.uses1 = 1; v.rs1 = 2; v.ex_mr = 1; v.ex_rd = 2;
    drive(v);
    m_pend = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    #1;
    chk_outputs("reset_in_pend", e_zero());
    @(posedge clk);
    @(negedge clk);
    drive(idle());
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cycle("post_reset_no_redirect", idle(), e_zero());

    // Long freeze to saturate the stall counter.
    v = idle(); v.busy = 1;
    drive(v);
    repeat (70000) @(posedge clk);
    #1;
    m_stall_cnt = (m_stall_cnt + 70000 > 65535) ? 65535 : m_stall_cnt + 70000;
    chk("stall_count_saturated", 32'(stall_count), 32'h0000_FFFF);
    run_cycle("stall_no_wrap", v, e_freeze());
    run_cycle("stall_no_wrap2", idle(), e_zero());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (asynchronous assert, active-low).
REQ-002 id_valid, id_uses_rs1, id_uses_rs2 input 1 each -- ID-stage instruction valid, and whether it reads rs1 / rs2.
REQ-003 id_rs1_addr, id_rs2_addr input 5 each -- ID-stage source register indices.
REQ-004 ex_valid, ex_reg_write, ex_mem_read input 1 each; ex_rd_addr input 5 -- EX-stage instruction qualifiers and destination.
REQ-005 ex_redirect_req input 1 -- EX requests a PC change (branch taken, JAL or JALR), qualified by ex_valid.
REQ-006 ex_redirect_addr input 32 -- target from the execute stage branch/jump address output.
REQ-007 mem_valid, mem_reg_write input 1 each; mem_rd_addr input 5 -- MEM-stage writer.
REQ-008 wb_valid, wb_reg_write input 1 each; wb_rd_addr input 5 -- WB-stage writer.
REQ-009 mem_busy input 1 -- data memory not ready; the whole pipeline must freeze.
REQ-010 fwd_rs1_sel, fwd_rs2_sel output 2 each -- 00 regfile, 01 MEM result, 10 WB result.
REQ-011 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall output 1 each -- hold PC / pipeline register.
REQ-012 if_id_flush, id_ex_flush output 1 each -- insert bubble (clear valid) on next edge.
REQ-013 pc_redirect_en output 1, pc_redirect_addr output 32 -- load PC with address on next edge.
REQ-014 stall_count, flush_count output 16 each -- saturating performance counters.

Function
REQ-015 Forwarding (combinational): rsN sel = 01 if mem_valid & mem_reg_write & mem_rd_addr==rsN & rsN!=0; else 10 if same test on WB; else 00; MEM beats WB.
REQ-016 Load-use hazard = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs1 & match rs1) | (id_uses_rs2 & match rs2)).
REQ-017 FSM states: RUN, PEND (redirect captured during freeze); encoding free.
REQ-018 Freeze (mem_busy=1): all four *_stall =1, both flushes =0, pc_redirect_en=0, regardless of state.
REQ-019 RUN, no freeze, ex_valid & ex_redirect_req: pc_redirect_en=1, pc_redirect_addr=ex_redirect_addr, if_id_flush=1, id_ex_flush=1, no stalls; load-use ignored that cycle.
REQ-020 RUN, no freeze, no redirect, load-use: pc_stall=1, if_id_stall=1, id_ex_flush=1; exactly one bubble per hazard instance.
REQ-021 RUN, mem_busy=1 & ex_valid & ex_redirect_req: latch ex_redirect_addr into pending register, go PEND.
REQ-022 PEND, mem_busy=1: remain PEND, freeze per REQ-018, pending address unchanged, ex_redirect_req ignored.
REQ-023 PEND, mem_busy=0: perform REQ-019 action using pending address (not current input), return RUN.
REQ-024 pc_redirect_addr SHALL equal 0 whenever pc_redirect_en=0.
REQ-025 stall_count +1 each cycle any *_stall=1; flush_count +1 each cycle if_id_flush or id_ex_flush=1; both saturate at 0xFFFF, no wrap.
REQ-026 Redirect latency zero cycles: PC loads target on the edge ending the request cycle; two wrong-path instructions discarded.

Reset
REQ-027 While rst_n=0: state RUN, pending address 0, counters 0; all stall/flush/redirect outputs 0, fwd sels 00.
REQ-028 Reset asserted while in PEND SHALL discard the pending redirect; no redirect after release.

Verification
REQ-029 EX load x5, ID add x6,x5,x7, mem_busy=0 -> one cycle pc_stall=if_id_stall=id_ex_flush=1; next cycle fwd_rs1_sel=01.
REQ-030 MEM and WB both write x3, ID reads x3 as rs2 -> fwd_rs2_sel=01; rd=x0 anywhere -> sel 00.
REQ-031 ex_redirect_req=1, addr 0x0000_0100, mem_busy=0 -> same cycle pc_redirect_en=1, addr 0x100, both flushes=1, flush_count +1.
REQ-032 redirect 0x200 with mem_busy=1 for 3 cycles -> 3 frozen cycles, no redirect; cycle mem_busy falls -> redirect to 0x200 even if input now 0x300.
REQ-033 Redirect and load-use same cycle -> redirect only, pc_stall=0.
REQ-034 rst_n low in PEND, release -> all outputs 0, counters 0, no redirect; hold stall 70000 cycles -> stall_count=0xFFFF.
